// File: rtl/dispatch_issue_ctrl.sv
// Dispatch/issue control: credit-gated dispatch with branch/JALR resolution FSM.
// Optional stall counters enabled by defining DISPATCH_PERF_CNT_EN.
module dispatch_issue_ctrl #(
  parameter int NUM_QUEUES     = 4,
  parameter int QUEUE_DEPTH    = 4,
  parameter int PERF_CNT_WIDTH = 32,
  localparam int CW = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ifq_empty,
  input  logic [NUM_QUEUES-1:0]    ctrl_queue_sel,
  input  logic                     ctrl_branch,
  input  logic                     ctrl_jmp_reg,
  input  logic                     ctrl_jmp,
  input  logic                     ctrl_needs_tag,
  input  logic                     tag_avail,
  input  logic [NUM_QUEUES-1:0]    queue_release,
  input  logic                     cdb_branch,
  input  logic                     cdb_branch_taken,
  input  logic                     cdb_jalr,
  output logic                     dpch_rd,
  output logic [NUM_QUEUES-1:0]    queue_push,
  output logic                     tag_pull,
  output logic                     branch_add_reg_en,
  output logic                     dpch_jmp,
  output logic [NUM_QUEUES*CW-1:0] credits,
`ifdef DISPATCH_PERF_CNT_EN
  output logic [PERF_CNT_WIDTH-1:0] stall_credit_cnt,
  output logic [PERF_CNT_WIDTH-1:0] stall_tag_cnt,
  output logic [PERF_CNT_WIDTH-1:0] stall_branch_cnt,
`endif
  output logic                     credit_err
);

  typedef enum logic [1:0] {
    DISPATCH,
    WAIT_BR,
    WAIT_JALR
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cred [NUM_QUEUES];
  logic            credit_ok;
  logic            tag_ok;
  logic            fire;

  // Every selected queue must have a free entry (covers illegal multi-hot).
  always_comb begin
    credit_ok = 1'b1;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (ctrl_queue_sel[i] && cred[i] == '0) credit_ok = 1'b0;
    end
  end

  assign tag_ok = !ctrl_needs_tag || tag_avail;
  assign fire   = !rst && state == DISPATCH && !ifq_empty
                  && credit_ok && tag_ok;

  always_comb begin
    state_nxt         = state;
    dpch_rd           = fire;
    queue_push        = fire ? ctrl_queue_sel : '0;
    tag_pull          = fire && ctrl_needs_tag;
    branch_add_reg_en = fire && ctrl_branch;
    dpch_jmp          = 1'b0;
    unique case (state)
      DISPATCH: begin
        dpch_jmp = fire && ctrl_jmp;
        if (fire && ctrl_branch) state_nxt = WAIT_BR;
        else if (fire && ctrl_jmp_reg) state_nxt = WAIT_JALR;
      end
      WAIT_BR: begin
        dpch_jmp = !rst && cdb_branch && cdb_branch_taken;
        if (cdb_branch) state_nxt = DISPATCH;
      end
      WAIT_JALR: begin
        dpch_jmp = !rst && cdb_jalr;
        if (cdb_jalr) state_nxt = DISPATCH;
      end
      default: state_nxt = DISPATCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= DISPATCH;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_err <= 1'b0;
      for (int i = 0; i < NUM_QUEUES; i++) cred[i] <= CW'(QUEUE_DEPTH);
    end else begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        if (queue_push[i] && !queue_release[i]) begin
          cred[i] <= cred[i] - 1'b1;
        end else if (!queue_push[i] && queue_release[i]) begin
          if (cred[i] == CW'(QUEUE_DEPTH)) credit_err <= 1'b1;
          else cred[i] <= cred[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    credits = '0;
    for (int i = 0; i < NUM_QUEUES; i++) credits[i*CW +: CW] = cred[i];
  end

`ifdef DISPATCH_PERF_CNT_EN
  logic blocked;
  assign blocked = !rst && !ifq_empty && !fire;

  // One cause per stalled cycle: FSM wait beats credit beats tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_credit_cnt <= '0;
      stall_tag_cnt    <= '0;
      stall_branch_cnt <= '0;
    end else if (blocked) begin
      if (state != DISPATCH) begin
        if (stall_branch_cnt != '1) stall_branch_cnt <= stall_branch_cnt + 1'b1;
      end else if (!credit_ok) begin
        if (stall_credit_cnt != '1) stall_credit_cnt <= stall_credit_cnt + 1'b1;
      end else if (!tag_ok) begin
        if (stall_tag_cnt != '1) stall_tag_cnt <= stall_tag_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_issue_ctrl.sv
// Directed scoreboard bench for dispatch_issue_ctrl (default 4 queues x 4 credits).
module tb_dispatch_issue_ctrl;

  localparam int NQ = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifq_empty;
  logic [NQ-1:0] ctrl_queue_sel;
  logic          ctrl_branch, ctrl_jmp_reg, ctrl_jmp, ctrl_needs_tag;
  logic          tag_avail;
  logic [NQ-1:0] queue_release;
  logic          cdb_branch, cdb_branch_taken, cdb_jalr;
  logic          dpch_rd;
  logic [NQ-1:0] queue_push;
  logic          tag_pull, branch_add_reg_en, dpch_jmp;
  logic [NQ*CW-1:0] credits;
  logic          credit_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          rd;
    logic [NQ-1:0] push;
    logic          pull;
    logic          bre;
    logic          jmp;
  } exp_t;

  exp_t sbq[$];

  dispatch_issue_ctrl dut (
    .clk(clk), .rst(rst), .ifq_empty(ifq_empty),
    .ctrl_queue_sel(ctrl_queue_sel), .ctrl_branch(ctrl_branch),
    .ctrl_jmp_reg(ctrl_jmp_reg), .ctrl_jmp(ctrl_jmp),
    .ctrl_needs_tag(ctrl_needs_tag), .tag_avail(tag_avail),
    .queue_release(queue_release), .cdb_branch(cdb_branch),
    .cdb_branch_taken(cdb_branch_taken), .cdb_jalr(cdb_jalr),
    .dpch_rd(dpch_rd), .queue_push(queue_push), .tag_pull(tag_pull),
    .branch_add_reg_en(branch_add_reg_en), .dpch_jmp(dpch_jmp),
    .credits(credits), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  task automatic expect_o(input logic rd, input logic [NQ-1:0] push,
                          input logic pull, input logic bre, input logic jmp);
    exp_t e;
    e.rd = rd; e.push = push; e.pull = pull; e.bre = bre; e.jmp = jmp;
    sbq.push_back(e);
  endtask

  // Inputs are driven at posedge+1; outputs sampled at posedge+4.
  task automatic step(input string tag);
    exp_t e, o;
    #3;
    o.rd = dpch_rd; o.push = queue_push; o.pull = tag_pull;
    o.bre = branch_add_reg_en; o.jmp = dpch_jmp;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, o);
    end else begin
      e = sbq.pop_front();
      assert (o === e) else begin
        errors++;
        $error("FAIL %s: observed rd/push/pull/bre/jmp=%b expected=%b", tag, o, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_cred(input string tag, input int q, input logic [CW-1:0] v);
    logic [CW-1:0] c;
    c = credits[q*CW +: CW];
    checks++;
    assert (c === v) else begin
      errors++;
      $error("FAIL %s: credits[%0d] observed=%0d expected=%0d", tag, q, c, v);
    end
  endtask

  task automatic check_err(input string tag, input logic v);
    checks++;
    assert (credit_err === v) else begin
      errors++;
      $error("FAIL %s: credit_err observed=%b expected=%b", tag, credit_err, v);
    end
  endtask

  initial begin
    rst = 1'b1; ifq_empty = 1'b0; ctrl_queue_sel = 4'b0001;
    ctrl_branch = 0; ctrl_jmp_reg = 0; ctrl_jmp = 1; ctrl_needs_tag = 0;
    tag_avail = 0; queue_release = '0;
    cdb_branch = 0; cdb_branch_taken = 0; cdb_jalr = 0;
    @(posedge clk); #1;
    // Reset cycle: outputs forced low despite a valid head
    expect_o(0, 4'b0000, 0, 0, 0); step("reset_outputs");
    rst = 1'b0; ctrl_jmp = 0;
    for (int q = 0; q < NQ; q++) check_cred("reset_credits", q, 3'd4);
    check_err("reset_err", 1'b0);

    // Credit exhaustion on ALU queue
    for (int i = 0; i < 4; i++) begin
      expect_o(1, 4'b0001, 0, 0, 0); step("alu_fire");
    end
    expect_o(0, 4'b0000, 0, 0, 0); step("alu_stall");
    check_cred("alu_exhausted", 0, 3'd0);
    ctrl_queue_sel = 4'b0011;
    expect_o(0, 4'b0000, 0, 0, 0); step("multihot_stall");
    ctrl_queue_sel = 4'b0001;
    queue_release = 4'b0001;
    expect_o(0, 4'b0000, 0, 0, 0); step("no_bypass");
    queue_release = '0;
    expect_o(1, 4'b0001, 0, 0, 0); step("alu_resume");
    check_cred("alu_after_resume", 0, 3'd0);
    ifq_empty = 1'b1; queue_release = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      expect_o(0, 4'b0000, 0, 0, 0); step("alu_refill");
    end
    queue_release = '0;
    check_cred("alu_refilled", 0, 3'd4);

    // Queue 1: push and release together hold the count
    ifq_empty = 1'b0; ctrl_queue_sel = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      expect_o(1, 4'b0010, 0, 0, 0); step("q1_fill");
    end
    check_cred("q1_at_two", 1, 3'd2);
    queue_release = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      expect_o(1, 4'b0010, 0, 0, 0); step("q1_push_rel");
    end
    check_cred("q1_held", 1, 3'd2);
    ifq_empty = 1'b1;
    for (int i = 0; i < 2; i++) begin
      expect_o(0, 4'b0000, 0, 0, 0); step("q1_refill");
    end
    queue_release = '0;
    check_cred("q1_refilled", 1, 3'd4);

    // CDB strobes in DISPATCH are ignored
    cdb_branch = 1; cdb_branch_taken = 1; cdb_jalr = 1;
    expect_o(0, 4'b0000, 0, 0, 0); step("cdb_ignored");
    cdb_branch = 0; cdb_branch_taken = 0; cdb_jalr = 0;

    // Taken branch
    ifq_empty = 1'b0; ctrl_queue_sel = 4'b0001; ctrl_branch = 1;
    expect_o(1, 4'b0001, 0, 1, 0); step("br_fire");
    ctrl_branch = 0; ctrl_queue_sel = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      expect_o(0, 4'b0000, 0, 0, 0); step("br_wait");
    end
    cdb_branch = 1; cdb_branch_taken = 1;
    expect_o(0, 4'b0000, 0, 0, 1); step("br_taken_jmp");
    cdb_branch = 0; cdb_branch_taken = 0;
    expect_o(1, 4'b0000, 0, 0, 0); step("br_taken_resume");

    // Not-taken branch
    ctrl_queue_sel = 4'b0001; ctrl_branch = 1;
    expect_o(1, 4'b0001, 0, 1, 0); step("br2_fire");
    ctrl_branch = 0; ctrl_queue_sel = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      expect_o(0, 4'b0000, 0, 0, 0); step("br2_wait");
    end
    cdb_branch = 1;
    expect_o(0, 4'b0000, 0, 0, 0); step("br_nt_nojmp");
    cdb_branch = 0;
    expect_o(1, 4'b0000, 0, 0, 0); step("br_nt_resume");
    check_cred("alu_after_branches", 0, 3'd2);

    // JAL waits for a tag, then fires with pull and jump
    ctrl_queue_sel = 4'b0001; ctrl_jmp = 1; ctrl_needs_tag = 1;
    expect_o(0, 4'b0000, 0, 0, 0); step("jal_no_tag");
    tag_avail = 1;
    expect_o(1, 4'b0001, 1, 0, 1); step("jal_fire");
    ctrl_jmp = 0; ctrl_jmp_reg = 1;
    expect_o(1, 4'b0001, 1, 0, 0); step("jalr_fire");
    ctrl_jmp_reg = 0; ctrl_needs_tag = 0; tag_avail = 0;
    check_cred("alu_after_jumps", 0, 3'd0);

    // In WAIT_JALR: overflow on queue 2, branch strobe ignored
    ifq_empty = 1'b1; ctrl_queue_sel = 4'b0000;
    queue_release = 4'b0100; cdb_branch = 1; cdb_branch_taken = 1;
    expect_o(0, 4'b0000, 0, 0, 0); step("jalr_wait_overflow");
    queue_release = '0; cdb_branch = 0; cdb_branch_taken = 0;
    check_err("overflow_err", 1'b1);
    check_cred("overflow_hold", 2, 3'd4);
    ifq_empty = 1'b0; ctrl_queue_sel = 4'b0001; ctrl_needs_tag = 0;
    expect_o(0, 4'b0000, 0, 0, 0); step("jalr_wait_blocked");

    // Reset discards the pending JALR
    rst = 1'b1; cdb_jalr = 1;
    expect_o(0, 4'b0000, 0, 0, 0); step("reset_mid_jalr");
    rst = 1'b0;
    for (int q = 0; q < NQ; q++) check_cred("rereset_credits", q, 3'd4);
    check_err("rereset_err", 1'b0);
    expect_o(1, 4'b0001, 0, 0, 0); step("post_reset_fire");
    cdb_jalr = 0;

    checks++;
    assert (sbq.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain: %0d entries left, expected 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
